fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low (0 = reset asserted); the port SHALL be named reset despite active-low polarity.
REQ-004 io_imem_req_valid  output  1  fetch request valid.
REQ-005 io_imem_req_addr  output  32  fetch address (current PC).
REQ-006 io_imem_req_ready  input  1  memory accepts request.
REQ-007 io_imem_resp_valid  input  1  instruction word returned.
REQ-008 io_imem_resp_data  input  32  instruction word.
REQ-009 io_redirect_valid  input  1  branch/jump redirect from later stage.
REQ-010 io_redirect_pc  input  32  redirect target.
REQ-011 io_id_stall  input  1  ID stage cannot accept this cycle.
REQ-012 io_id_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 io_id_pc  output  32  PC of IF/ID instruction.
REQ-014 io_id_inst  output  32  IF/ID instruction word.
REQ-015 io_fetch_count  output  32  instructions delivered into IF/ID.
REQ-016 io_state  output  3  FSM state, debug only.

Function
REQ-017 FSM states SHALL be IDLE=0, REQ=1, WAIT=2, BUF=3, DRAIN=4; at most one memory request outstanding.
REQ-018 io_imem_req_valid SHALL be 1 only in REQ; io_imem_req_addr SHALL equal the PC register in all states.
REQ-019 IDLE -> REQ unconditionally on the next cycle.
REQ-020 REQ: handshake (req_valid & req_ready) -> WAIT; else stay REQ.
REQ-021 ID consumes IF/ID when io_id_valid=1 and io_id_stall=0; IF/ID slot is free when io_id_valid=0 or consumed this cycle.
REQ-022 WAIT with resp_valid and slot free: IF/ID <= {PC, resp_data}, valid=1, PC <= PC+4 (mod 2^32), -> REQ.
REQ-023 WAIT with resp_valid and slot not free: resp_data and PC SHALL be captured in a one-entry skid buffer, PC <= PC+4, -> BUF.
REQ-024 BUF: no request issued; when slot free, IF/ID <= skid buffer, -> REQ; else hold.
REQ-025 If IF/ID is consumed and no new word loads that cycle, io_id_valid SHALL become 0.
REQ-026 Redirect SHALL take priority over stall and over response delivery: IF/ID valid <= 0, skid buffer discarded, PC <= io_redirect_pc.
REQ-027 Redirect next-state: REQ with handshake same cycle -> DRAIN; REQ without handshake -> REQ; WAIT with resp_valid same cycle (response discarded) -> REQ; WAIT without resp_valid -> DRAIN; BUF -> REQ; DRAIN with resp_valid -> REQ; DRAIN without resp_valid -> DRAIN (PC updated again); IDLE -> REQ with redirect PC.
REQ-028 DRAIN: no request; on resp_valid the word SHALL be discarded, -> REQ.
REQ-029 io_fetch_count SHALL increment by 1 per word written into IF/ID (REQ-022, REQ-024), never for discarded words, wrapping 2^32-1 -> 0.
REQ-030 resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-031 Best-case throughput: one instruction per 2 cycles with single-cycle memory latency (REQ->WAIT->REQ).

Reset
REQ-032 While reset=0 at a clock edge: state<=IDLE, PC<=RESET_PC, io_id_valid<=0, io_id_pc<=0, io_id_inst<=0, skid buffer invalid, io_fetch_count<=0.
REQ-033 All outputs SHALL reflect reset values from the first edge with reset=0; io_imem_req_valid=0 in IDLE.
REQ-034 Reset asserted mid-operation (any state, request outstanding) SHALL abort it; any later response SHALL be ignored per REQ-030.

Verification
REQ-035 Reset release, req_ready=1, resp one cycle after handshake, data 0x00000013 -> first req addr 0x0, io_id_valid=1 with pc 0x0, inst 0x13, next req addr 0x4, count=1.
REQ-036 IF/ID valid, io_id_stall=1 held 5 cycles, response 0xAAAA0001 at pc 0x8 -> state BUF, no req_valid; stall release -> IF/ID pc 0x8 inst 0xAAAA0001, next req addr 0xC.
REQ-037 Redirect to 0x100 in WAIT with no response -> DRAIN, IF/ID invalid; next response discarded, count unchanged; next req addr 0x100.
REQ-038 Redirect to 0x200 same cycle as resp_valid with io_id_stall=1 -> response discarded, IF/ID invalid, state REQ, req addr 0x200.
REQ-039 PC 0xFFFFFFFC fetched -> next req addr 0x0; count preloaded to 0xFFFFFFFF via stimulus -> delivery wraps count to 0.
REQ-040 reset=0 asserted in WAIT, response arrives during/after reset -> ignored, state IDLE then REQ, req addr RESET_PC, count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, IF/ID register,
// one-entry skid buffer for responses that arrive while ID is stalled.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_req_ready,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  input  logic        io_id_stall,
  output logic        io_id_valid,
  output logic [31:0] io_id_pc,
  output logic [31:0] io_id_inst,
  output logic [31:0] io_fetch_count,
  output logic [2:0]  io_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    BUF   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        req_valid_r;
  logic        id_valid_r, id_valid_s;
  logic [31:0] id_pc_r, id_pc_s;
  logic [31:0] id_inst_r, id_inst_s;
  logic [31:0] skid_pc_r, skid_pc_s;
  logic [31:0] skid_inst_r, skid_inst_s;
  logic [31:0] fetch_count_r;
  logic        count_inc_s;
  logic        consume_s;
  logic        slot_free_s;
  logic        handshake_s;

  assign consume_s   = id_valid_r & ~io_id_stall;
  assign slot_free_s = ~id_valid_r | consume_s;
  assign handshake_s = (state_r == REQ) & io_imem_req_ready;

  // Next-state, PC, IF/ID and skid buffer; redirect overrides stall and delivery
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    id_valid_s  = id_valid_r & ~consume_s;
    id_pc_s     = id_pc_r;
    id_inst_s   = id_inst_r;
    skid_pc_s   = skid_pc_r;
    skid_inst_s = skid_inst_r;
    count_inc_s = 1'b0;
    if (io_redirect_valid) begin
      id_valid_s = 1'b0;
      pc_s       = io_redirect_pc;
      case (state_r)
        IDLE:    state_s = REQ;
        REQ:     state_s = handshake_s ? DRAIN : REQ;
        WAIT:    state_s = io_imem_resp_valid ? REQ : DRAIN;
        BUF:     state_s = REQ;
        DRAIN:   state_s = io_imem_resp_valid ? REQ : DRAIN;
        default: state_s = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: state_s = REQ;
        REQ: begin
          if (handshake_s) begin
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end
        WAIT: begin
          if (io_imem_resp_valid) begin
            pc_s = pc_r + 32'd4;
            if (slot_free_s) begin
              id_valid_s  = 1'b1;
              id_pc_s     = pc_r;
              id_inst_s   = io_imem_resp_data;
              count_inc_s = 1'b1;
              state_s     = REQ;
            end else begin
              skid_pc_s   = pc_r;
              skid_inst_s = io_imem_resp_data;
              state_s     = BUF;
            end
          end else begin
            state_s = WAIT;
          end
        end
        BUF: begin
          if (slot_free_s) begin
            id_valid_s  = 1'b1;
            id_pc_s     = skid_pc_r;
            id_inst_s   = skid_inst_r;
            count_inc_s = 1'b1;
            state_s     = REQ;
          end else begin
            state_s = BUF;
          end
        end
        DRAIN: begin
          if (io_imem_resp_valid) begin
            state_s = REQ;
          end else begin
            state_s = DRAIN;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      req_valid_r   <= 1'b0;
      id_valid_r    <= 1'b0;
      id_pc_r       <= 32'd0;
      id_inst_r     <= 32'd0;
      skid_pc_r     <= 32'd0;
      skid_inst_r   <= 32'd0;
      fetch_count_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      req_valid_r <= (state_s == REQ);
      id_valid_r  <= id_valid_s;
      id_pc_r     <= id_pc_s;
      id_inst_r   <= id_inst_s;
      skid_pc_r   <= skid_pc_s;
      skid_inst_r <= skid_inst_s;
      if (count_inc_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
    end
  end

  assign io_imem_req_valid = req_valid_r;
  assign io_imem_req_addr  = pc_r;
  assign io_id_valid       = id_valid_r;
  assign io_id_pc          = id_pc_r;
  assign io_id_inst        = id_inst_r;
  assign io_fetch_count    = fetch_count_r;
  assign io_state          = state_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, basic fetch, stall/skid, redirects,
// PC and counter wrap, and reset during an outstanding request.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_imem_req_valid;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_req_ready;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_id_stall;
  logic        io_id_valid;
  logic [31:0] io_id_pc;
  logic [31:0] io_id_inst;
  logic [31:0] io_fetch_count;
  logic [2:0]  io_state;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_id_stall        (io_id_stall),
    .io_id_valid        (io_id_valid),
    .io_id_pc           (io_id_pc),
    .io_id_inst         (io_id_inst),
    .io_fetch_count     (io_fetch_count),
    .io_state           (io_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset              = 1'b0;
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = 32'd0;
    io_redirect_valid  = 1'b0;
    io_redirect_pc     = 32'd0;
    io_id_stall        = 1'b0;

    // reset state
    step(); step();
    chk("rst_state", 32'(io_state), 32'd0);
    chk("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
    chk("rst_addr", io_imem_req_addr, 32'h0);
    chk("rst_id_valid", 32'(io_id_valid), 32'd0);
    chk("rst_id_pc", io_id_pc, 32'h0);
    chk("rst_id_inst", io_id_inst, 32'h0);
    chk("rst_count", io_fetch_count, 32'd0);

    // first fetch
    reset = 1'b1;
    step();
    chk("f1_state_req", 32'(io_state), 32'd1);
    chk("f1_req_valid", 32'(io_imem_req_valid), 32'd1);
    chk("f1_addr", io_imem_req_addr, 32'h0);
    io_imem_req_ready = 1'b1;
    step();
    chk("f1_state_wait", 32'(io_state), 32'd2);
    chk("f1_wait_no_req", 32'(io_imem_req_valid), 32'd0);
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h0000_0013;
    step();
    chk("f1_id_valid", 32'(io_id_valid), 32'd1);
    chk("f1_id_pc", io_id_pc, 32'h0);
    chk("f1_id_inst", io_id_inst, 32'h0000_0013);
    chk("f1_next_addr", io_imem_req_addr, 32'h4);
    chk("f1_count", io_fetch_count, 32'd1);
    chk("f1_state_req2", 32'(io_state), 32'd1);

    // second fetch at pc 4, first word consumed
    io_imem_resp_valid = 1'b0;
    io_imem_req_ready  = 1'b1;
    step();
    chk("f2_wait", 32'(io_state), 32'd2);
    chk("f2_consumed", 32'(io_id_valid), 32'd0);
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h0010_0093;
    step();
    chk("f2_id_pc", io_id_pc, 32'h4);
    chk("f2_count", io_fetch_count, 32'd2);

    // stall held 5 cycles, response at pc 8 goes to skid buffer
    io_imem_resp_valid = 1'b0;
    io_id_stall        = 1'b1;
    io_imem_req_ready  = 1'b1;
    step();
    chk("s_wait", 32'(io_state), 32'd2);
    chk("s_addr8", io_imem_req_addr, 32'h8);
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'hAAAA_0001;
    step();
    chk("s_buf", 32'(io_state), 32'd3);
    chk("s_buf_no_req", 32'(io_imem_req_valid), 32'd0);
    chk("s_id_pc_held", io_id_pc, 32'h4);
    chk("s_count_held", io_fetch_count, 32'd2);
    io_imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_buf_hold", 32'(io_state), 32'd3);
      chk("s_buf_hold_req", 32'(io_imem_req_valid), 32'd0);
    end
    io_id_stall = 1'b0;
    step();
    chk("s_rel_id_pc", io_id_pc, 32'h8);
    chk("s_rel_id_inst", io_id_inst, 32'hAAAA_0001);
    chk("s_rel_id_valid", 32'(io_id_valid), 32'd1);
    chk("s_rel_addr", io_imem_req_addr, 32'hC);
    chk("s_rel_count", io_fetch_count, 32'd3);
    chk("s_rel_req_valid", 32'(io_imem_req_valid), 32'd1);

    // redirect in WAIT without response -> DRAIN
    io_id_stall       = 1'b1;
    io_imem_req_ready = 1'b1;
    step();
    chk("d_wait", 32'(io_state), 32'd2);
    chk("d_id_held", 32'(io_id_valid), 32'd1);
    io_imem_req_ready = 1'b0;
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h0000_0100;
    step();
    chk("d_drain", 32'(io_state), 32'd4);
    chk("d_id_invalid", 32'(io_id_valid), 32'd0);
    chk("d_drain_no_req", 32'(io_imem_req_valid), 32'd0);
    io_redirect_valid  = 1'b0;
    io_id_stall        = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'hDEAD_BEEF;
    step();
    chk("d_state_req", 32'(io_state), 32'd1);
    chk("d_count", io_fetch_count, 32'd3);
    chk("d_discard", 32'(io_id_valid), 32'd0);
    chk("d_addr", io_imem_req_addr, 32'h100);

    // deliver at 0x100, then redirect coinciding with response under stall
    io_imem_resp_valid = 1'b0;
    io_imem_req_ready  = 1'b1;
    step();
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h1111_1111;
    step();
    chk("r_id_pc", io_id_pc, 32'h100);
    chk("r_count", io_fetch_count, 32'd4);
    io_imem_resp_valid = 1'b0;
    io_imem_req_ready  = 1'b1;
    io_id_stall        = 1'b1;
    step();
    chk("r_wait", 32'(io_state), 32'd2);
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h2222_2222;
    io_redirect_valid  = 1'b1;
    io_redirect_pc     = 32'h0000_0200;
    step();
    chk("r_state_req", 32'(io_state), 32'd1);
    chk("r_id_invalid", 32'(io_id_valid), 32'd0);
    chk("r_addr", io_imem_req_addr, 32'h200);
    chk("r_count_same", io_fetch_count, 32'd4);
    chk("r_req_valid", 32'(io_imem_req_valid), 32'd1);

    // PC wrap and count wrap
    io_imem_resp_valid = 1'b0;
    io_id_stall        = 1'b0;
    io_redirect_pc     = 32'hFFFF_FFFC;
    step();
    chk("w_state_req", 32'(io_state), 32'd1);
    chk("w_addr", io_imem_req_addr, 32'hFFFF_FFFC);
    io_redirect_valid = 1'b0;
    force dut.fetch_count_r = 32'hFFFF_FFFF;
    #2;
    release dut.fetch_count_r;
    io_imem_req_ready = 1'b1;
    step();
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h0000_006F;
    step();
    chk("w_id_pc", io_id_pc, 32'hFFFF_FFFC);
    chk("w_next_addr", io_imem_req_addr, 32'h0);
    chk("w_count_wrap", io_fetch_count, 32'd0);

    // reset during an outstanding request
    io_imem_resp_valid = 1'b0;
    io_imem_req_ready  = 1'b1;
    step();
    chk("x_wait", 32'(io_state), 32'd2);
    io_imem_req_ready = 1'b0;
    reset             = 1'b0;
    step();
    chk("x_idle", 32'(io_state), 32'd0);
    chk("x_count", io_fetch_count, 32'd0);
    chk("x_id_invalid", 32'(io_id_valid), 32'd0);
    chk("x_no_req", 32'(io_imem_req_valid), 32'd0);
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h1234_5678;
    step();
    chk("x_idle_hold", 32'(io_state), 32'd0);
    reset = 1'b1;
    step();
    chk("x_req", 32'(io_state), 32'd1);
    chk("x_addr", io_imem_req_addr, 32'h0);
    chk("x_count_after", io_fetch_count, 32'd0);
    chk("x_id_after", 32'(io_id_valid), 32'd0);
    io_imem_resp_valid = 1'b0;
    step();
    chk("x_req_stay", 32'(io_state), 32'd1);
    chk("x_req_valid", 32'(io_imem_req_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
